// File: rtl/cn_ib_pkg.sv
// Shared types and defaults for the IB-ROM to CN-memory load controller.
// Holds the FSM encoding and the address-width consistency check.
package cn_ib_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } cn_ib_state_e;

  localparam int CN_PAGE_NUM    = 32;
  localparam int CN_ITER_MAX    = 25;
  localparam int CN_ROM_LATENCY = 1;

  // ROM address is {iteration, page}; both fields must fill it exactly.
  function automatic bit addr_bw_ok(
    input int rom_bw,
    input int iter_bw,
    input int page_bw
  );
    return rom_bw == iter_bw + page_bw;
  endfunction

endpackage

// File: rtl/cn_ib_wr_align.sv
// Run counter and write strobe / page address aligned to the ROM
// read latency plus the one-cycle latch stage.
module cn_ib_wr_align
  import cn_ib_pkg::*;
#(
  parameter int PAGE_ADDR_BW = 5,
  parameter int ROM_LATENCY  = CN_ROM_LATENCY
) (
  input  logic                    write_clk,
  input  logic                    rstn,
  input  logic                    run,
  output logic [PAGE_ADDR_BW:0]   run_cnt,
  output logic                    cn_wr_en,
  output logic [PAGE_ADDR_BW-1:0] cn_wr_page_addr
);

  localparam int CW = PAGE_ADDR_BW + 1;
  localparam logic [CW-1:0] WR_FIRST = CW'(ROM_LATENCY + 1);

  logic [PAGE_ADDR_BW-1:0] page_off;
  logic [PAGE_ADDR_BW-1:0] page_q;

  // Count RUN cycles from 0; parked at 0 outside RUN.
  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn)
      run_cnt <= '0;
    else if (run)
      run_cnt <= run_cnt + 1'b1;
    else
      run_cnt <= '0;
  end

  assign cn_wr_en = run && (run_cnt >= WR_FIRST);
  assign page_off = PAGE_ADDR_BW'(run_cnt - WR_FIRST);

  // Remember the last written page so the address holds when idle.
  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn)
      page_q <= '0;
    else if (cn_wr_en)
      page_q <= page_off;
  end

  assign cn_wr_page_addr = cn_wr_en ? page_off : page_q;

endmodule

// File: rtl/cn_ib_load_ctrl.sv
// Load sequencer for IB-ROM check-node tables: FSM, iteration index,
// pending-update handling and latch control toward CN memory.
module cn_ib_load_ctrl
  import cn_ib_pkg::*;
#(
  parameter int ROM_RD_BW    = 6,
  parameter int ROM_ADDR_BW  = 10,
  parameter int PAGE_ADDR_BW = 5,
  parameter int ITER_ADDR_BW = 5,
  parameter int PAGE_NUM     = CN_PAGE_NUM,
  parameter int ITER_MAX     = CN_ITER_MAX,
  parameter int ROM_LATENCY  = CN_ROM_LATENCY
) (
  input  logic                    write_clk,
  input  logic                    rstn,
  input  logic                    decode_start,
  input  logic                    iter_update,
  output logic                    rom_port_fetch,
  output logic [ITER_ADDR_BW-1:0] rom_iter_addrA,
  output logic [ITER_ADDR_BW-1:0] rom_iter_addrB,
  output logic                    cn_wr_en,
  output logic [PAGE_ADDR_BW-1:0] cn_wr_page_addr,
  output logic [ITER_ADDR_BW-1:0] iter_cnt,
  output logic                    busy,
  output logic                    load_done,
  output logic                    last_iter
);

  localparam int CW = PAGE_ADDR_BW + 1;
  localparam logic [CW-1:0] RUN_END = CW'(PAGE_NUM + ROM_LATENCY);
  localparam logic [ITER_ADDR_BW-1:0] ITER_LAST =
    ITER_ADDR_BW'(ITER_MAX - 1);

  if (!addr_bw_ok(ROM_ADDR_BW, ITER_ADDR_BW, PAGE_ADDR_BW) ||
      ROM_RD_BW < 1) begin : g_bad_bw
    $error("cn_ib_load_ctrl: ROM_ADDR_BW != ITER_ADDR_BW + PAGE_ADDR_BW");
  end

  cn_ib_state_e            state_q, state_d;
  logic [ITER_ADDR_BW-1:0] iter_q, iter_d;
  logic [ITER_ADDR_BW-1:0] addr_q;
  logic                    pend_q, pend_d;
  logic                    rs_q, rs_d;
  logic                    enter;
  logic                    upd_ok;
  logic [CW-1:0]           run_cnt;

  assign last_iter = (iter_q == ITER_LAST);
  assign upd_ok    = iter_update && !decode_start && !last_iter && !pend_q;

  // Next state, iteration index, pending update and restart flag.
  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    pend_d  = pend_q;
    rs_d    = rs_q;
    enter   = 1'b0;
    if (decode_start) begin
      iter_d = '0;
      pend_d = 1'b0;
      if (state_q == ST_IDLE) begin
        state_d = ST_RUN;
        enter   = 1'b1;
        rs_d    = 1'b0;
      end else begin
        state_d = ST_IDLE;
        rs_d    = 1'b1;
      end
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (rs_q) begin
            state_d = ST_RUN;
            enter   = 1'b1;
            rs_d    = 1'b0;
          end else if (upd_ok) begin
            iter_d  = iter_q + 1'b1;
            state_d = ST_RUN;
            enter   = 1'b1;
          end
        end
        ST_RUN: begin
          if (upd_ok)
            pend_d = 1'b1;
          if (run_cnt == RUN_END)
            state_d = ST_DONE;
        end
        ST_DONE: begin
          if (pend_q || upd_ok) begin
            iter_d  = iter_q + 1'b1;
            pend_d  = 1'b0;
            state_d = ST_RUN;
            enter   = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      iter_q  <= '0;
      pend_q  <= 1'b0;
      rs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      pend_q  <= pend_d;
      rs_q    <= rs_d;
    end
  end

  // Latch base index only moves when a load begins.
  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn)
      addr_q <= '0;
    else if (enter)
      addr_q <= iter_d;
  end

  assign rom_port_fetch = (state_q == ST_RUN);
  assign busy           = (state_q != ST_IDLE);
  assign load_done      = (state_q == ST_DONE);
  assign iter_cnt       = iter_q;
  assign rom_iter_addrA = addr_q;
  assign rom_iter_addrB = addr_q;

  cn_ib_wr_align #(
    .PAGE_ADDR_BW (PAGE_ADDR_BW),
    .ROM_LATENCY  (ROM_LATENCY)
  ) u_wr_align (
    .write_clk       (write_clk),
    .rstn            (rstn),
    .run             (rom_port_fetch),
    .run_cnt         (run_cnt),
    .cn_wr_en        (cn_wr_en),
    .cn_wr_page_addr (cn_wr_page_addr)
  );

endmodule

// File: tb/tb_cn_ib_load_ctrl.sv
// Bench for cn_ib_load_ctrl: scoreboard of expected writes and
// load completions, plus a short-table, long-latency instance.
module tb_cn_ib_load_ctrl;

  logic       write_clk;
  logic       rstn;
  logic       ds, iu;
  logic       fetch, wr_en, busy, done, last;
  logic [4:0] iter_a, iter_b, page, iter_cnt;

  logic       ds2, iu2;
  logic       fetch2, wr_en2, busy2, done2, last2;
  logic [4:0] iter_a2, iter_b2, page2, iter_cnt2;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  int c0;

  typedef struct { int cyc; int it; int pg; } wr_t;
  typedef struct { int cyc; int it; } done_t;

  wr_t   wr_q[$];
  done_t done_q[$];
  wr_t   w;
  done_t d;

  cn_ib_load_ctrl u_dut (
    .write_clk       (write_clk),
    .rstn            (rstn),
    .decode_start    (ds),
    .iter_update     (iu),
    .rom_port_fetch  (fetch),
    .rom_iter_addrA  (iter_a),
    .rom_iter_addrB  (iter_b),
    .cn_wr_en        (wr_en),
    .cn_wr_page_addr (page),
    .iter_cnt        (iter_cnt),
    .busy            (busy),
    .load_done       (done),
    .last_iter       (last)
  );

  cn_ib_load_ctrl #(
    .PAGE_NUM    (4),
    .ROM_LATENCY (3)
  ) u_lat (
    .write_clk       (write_clk),
    .rstn            (rstn),
    .decode_start    (ds2),
    .iter_update     (iu2),
    .rom_port_fetch  (fetch2),
    .rom_iter_addrA  (iter_a2),
    .rom_iter_addrB  (iter_b2),
    .cn_wr_en        (wr_en2),
    .cn_wr_page_addr (page2),
    .iter_cnt        (iter_cnt2),
    .busy            (busy2),
    .load_done       (done2),
    .last_iter       (last2)
  );

  initial write_clk = 1'b0;
  always #5 write_clk = ~write_clk;

  always @(posedge write_clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge write_clk);
    #1;
  endtask

  // Expected writes for a load whose first RUN cycle is c (latency 1).
  task automatic push_load(input int c, input int it);
    for (int p = 0; p < 32; p++)
      wr_q.push_back('{cyc: c + 2 + p, it: it, pg: p});
    done_q.push_back('{cyc: c + 34, it: it});
  endtask

  task automatic start_load(input bit use_start, input int it);
    if (use_start) ds = 1'b1;
    else iu = 1'b1;
    push_load(cyc + 1, it);
    tick();
    ds = 1'b0;
    iu = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    if (done_q.size() != 0) begin
      chk("timeout", done_q.size(), 0);
      wr_q.delete();
      done_q.delete();
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  // Scoreboard: pop and compare on every observed write and completion.
  always @(negedge write_clk) begin
    if (rstn) begin
      if (wr_en) begin
        if (wr_q.size() == 0) chk("spur_wr", 1, 0);
        else begin
          w = wr_q.pop_front();
          chk("wr_cyc", cyc, w.cyc);
          chk("wr_page", page, w.pg);
          chk("wr_iterA", iter_a, w.it);
          chk("wr_iterB", iter_b, w.it);
        end
      end
      if (done) begin
        if (done_q.size() == 0) chk("spur_done", 1, 0);
        else begin
          d = done_q.pop_front();
          chk("done_cyc", cyc, d.cyc);
          chk("done_iter", iter_cnt, d.it);
        end
      end
    end
  end

  initial begin
    rstn = 1'b0;
    ds   = 1'b0;
    iu   = 1'b0;
    ds2  = 1'b0;
    iu2  = 1'b0;
    repeat (3) tick();
    chk("rst_fetch", fetch, 0);
    chk("rst_wr", wr_en, 0);
    chk("rst_page", page, 0);
    chk("rst_iterA", iter_a, 0);
    chk("rst_iterB", iter_b, 0);
    chk("rst_iter", iter_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_last", last, 0);
    rstn = 1'b1;
    tick();

    start_load(1'b1, 0);
    chk("run_fetch", fetch, 1);
    chk("run_busy", busy, 1);
    wait_done();
    chk("basic_iter", iter_cnt, 0);
    chk("basic_fetch", fetch, 0);

    for (int i = 1; i <= 24; i++) begin
      start_load(1'b0, i);
      wait_done();
      chk("it_cnt", iter_cnt, i);
      chk("it_addrA", iter_a, i);
      chk("it_addrB", iter_b, i);
      chk("it_last", last, (i == 24) ? 1 : 0);
    end
    iu = 1'b1;
    tick();
    iu = 1'b0;
    chk("drop_busy", busy, 0);
    repeat (40) tick();
    chk("drop_iter", iter_cnt, 24);

    start_load(1'b1, 0);
    c0 = cyc;
    wait_until(c0 + 10);
    iu = 1'b1;
    push_load(c0 + 35, 1);
    tick();
    iu = 1'b0;
    wait_until(c0 + 34);
    chk("gap_fetch", fetch, 0);
    chk("gap_busy", busy, 1);
    tick();
    chk("b2b_fetch", fetch, 1);
    wait_done();
    chk("pend_iter", iter_cnt, 1);

    start_load(1'b0, 2);
    c0 = cyc;
    wait_until(c0 + 5);
    iu = 1'b1;
    push_load(c0 + 35, 3);
    tick();
    iu = 1'b0;
    wait_until(c0 + 8);
    iu = 1'b1;
    tick();
    iu = 1'b0;
    wait_done();
    repeat (40) tick();
    chk("dbl_iter", iter_cnt, 3);

    start_load(1'b0, 4);
    wait_done();
    start_load(1'b0, 5);
    c0 = cyc;
    wait_until(c0 + 20);
    ds = 1'b1;
    tick();
    ds = 1'b0;
    wr_q.delete();
    done_q.delete();
    chk("ab_wr", wr_en, 0);
    chk("ab_fetch", fetch, 0);
    chk("ab_done", done, 0);
    chk("ab_iter", iter_cnt, 0);
    push_load(c0 + 22, 0);
    wait_done();
    chk("ab_iter2", iter_cnt, 0);

    start_load(1'b1, 0);
    c0 = cyc;
    wait_until(c0 + 7);
    rstn = 1'b0;
    #1;
    chk("mr_fetch", fetch, 0);
    chk("mr_wr", wr_en, 0);
    chk("mr_page", page, 0);
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    wr_q.delete();
    done_q.delete();
    #3;
    rstn = 1'b1;
    repeat (50) tick();
    chk("mr_idle", busy, 0);

    ds2 = 1'b1;
    tick();
    ds2 = 1'b0;
    for (int r = 0; r < 10; r++) begin
      chk("lat_wr", wr_en2, (r >= 4 && r <= 7) ? 1 : 0);
      if (r >= 4 && r <= 7) chk("lat_page", page2, r - 4);
      chk("lat_done", done2, (r == 8) ? 1 : 0);
      chk("lat_fetch", fetch2, (r <= 7) ? 1 : 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
